// File: rtl/instr_fetch_pkg.sv
// instr_fetch shared types and constants.
// Fetch state encoding, buffer entry layout, PC helpers.
package instr_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_inc(
    input logic [ADDR_W-1:0] pc
  );
    return pc + PC_STEP;
  endfunction

  function automatic logic [ADDR_W-1:0] pc_align(
    input logic [ADDR_W-1:0] pc
  );
    return {pc[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch bus: imem port, redirect, decode handoff.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic [ADDR_W-1:0]  ir_next_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output ir_valid,
    input  ir_ready,
    output ir,
    output ir_pc,
    output ir_next_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  ir_valid,
    output ir_ready,
    input  ir,
    input  ir_pc,
    input  ir_next_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction buffer of {instr, pc}.
// Push and pop may coincide, even when full.
module fetch_buffer
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  fetch_entry_t mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  // Pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      wptr  <= wptr ^ do_push;
      rptr  <= rptr ^ do_pop;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) begin
      mem[wptr] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential 16-bit fetch into a
// two-entry buffer, with redirect and in-flight drop.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  instr_fetch_if.master     bus
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] drop_addr;
  logic [ADDR_W-1:0] tgt;
  logic              req_live;
  logic              ack;
  logic              push;
  logic              pop;
  logic              fill;
  logic              full;
  logic              empty;
  fetch_entry_t      din;
  fetch_entry_t      head;

  assign tgt      = pc_align(bus.redirect_pc);
  assign req_live = ~reset & (state != S_HOLD);
  assign ack      = req_live & bus.imem_ack;
  assign pop      = ~empty & bus.ir_ready & ~bus.redirect;
  assign push     = (state == S_REQ) & ack & ~bus.redirect;
  assign fill     = full | (~empty & ~pop);
  assign din      = '{instr: bus.imem_rdata, pc: fetch_pc};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock (clock),
    .reset (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Fetch FSM; redirect wins over every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_REQ;
      fetch_pc  <= pc_align(RESET_PC);
      drop_addr <= pc_align(RESET_PC);
    end else if (bus.redirect) begin
      fetch_pc <= tgt;
      unique case (state)
        S_REQ: begin
          if (!ack) begin
            state     <= S_DROP;
            drop_addr <= fetch_pc;
          end
        end
        S_HOLD: state <= S_REQ;
        S_DROP: if (ack) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (ack) begin
            fetch_pc <= pc_inc(fetch_pc);
            if (fill) state <= S_HOLD;
          end
        end
        S_HOLD: if (pop) state <= S_REQ;
        S_DROP: if (ack) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req  = req_live;
  assign bus.imem_addr = (state == S_DROP) ? drop_addr
                                           : fetch_pc;

  assign bus.ir_valid   = ~empty;
  assign bus.ir         = empty ? '0 : head.instr;
  assign bus.ir_pc      = empty ? '0 : head.pc;
  assign bus.ir_next_pc = pc_inc(bus.ir_pc);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, byte address of the first instruction fetched after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; only the value 2 is supported.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  16  byte address of the requested 16-bit instruction; bit 0 is always 0.
REQ-007 imem_ack  input  1  memory response strobe; imem_rdata is valid in the cycle imem_ack=1.
REQ-008 imem_rdata  input  16  instruction word returned by memory.
REQ-009 redirect  input  1  branch/jump taken; overrides sequential fetch.
REQ-010 redirect_pc  input  16  target byte address; bit 0 ignored and treated as 0.
REQ-011 ir_valid  output  1  ir/ir_pc hold a valid instruction for the decode stage.
REQ-012 ir_ready  input  1  decode stage accepts the head instruction this cycle.
REQ-013 ir  output  16  head instruction word; 16'h0000 when ir_valid=0.
REQ-014 ir_pc  output  16  byte address of ir; 16'h0000 when ir_valid=0.
REQ-015 ir_next_pc  output  16  ir_pc+2 mod 2^16, used by decode for branch base.

Function
REQ-016 The block SHALL hold fetch_pc, a 2-entry FIFO of {instr, pc}, and a state machine with states REQ, HOLD, DROP.
REQ-017 REQ: imem_req=1, imem_addr=fetch_pc; on imem_ack the SHALL push {imem_rdata, fetch_pc}, advance fetch_pc by 2, and go to HOLD if the FIFO is then full, otherwise stay in REQ.
REQ-018 While imem_req=1 and imem_ack=0, imem_addr SHALL remain stable.
REQ-019 HOLD: imem_req=0; SHALL return to REQ in the cycle after a FIFO pop leaves a free entry.
REQ-020 Pop SHALL occur when ir_valid=1 and ir_ready=1; push and pop in the same cycle SHALL both take effect, including when full.
REQ-021 ir_valid SHALL equal FIFO non-empty; ir, ir_pc SHALL be the FIFO head (registered, no combinational path from imem_rdata).
REQ-022 fetch_pc arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 = 16'h0000.
REQ-023 Latency: with a zero-wait memory (ack in the request cycle), an instruction SHALL appear on ir one cycle after its ack; sustained throughput one instruction per cycle while ir_ready=1.
REQ-024 redirect SHALL have priority over all other events: FIFO flushed (ir_valid=0 next cycle), any same-cycle pop/push discarded, fetch_pc <= {redirect_pc[15:1],1'b0}.
REQ-025 On redirect with a request outstanding and imem_ack=0, state SHALL go to DROP; with imem_ack=1 or from HOLD, state SHALL go to REQ.
REQ-026 DROP: imem_req=1 with the old address held; on imem_ack data SHALL be discarded and state SHALL go to REQ fetching fetch_pc.
REQ-027 redirect during DROP SHALL update fetch_pc and remain in DROP.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 While reset=1: imem_req=0, ir_valid=0, ir=0, ir_pc=0, FIFO empty, fetch_pc=RESET_PC, state=REQ.
REQ-030 reset mid-operation SHALL abandon any outstanding request (imem_req drops next cycle) and discard buffered instructions.
REQ-031 The first cycle after reset deasserts SHALL present imem_req=1, imem_addr=RESET_PC.

Structure
REQ-032 Shared package SHALL hold INSTR_W=16, ADDR_W=16, PC_STEP=2 and the REQ/HOLD/DROP state encoding.
REQ-033 The FIFO SHALL be a separate sub-module fetch_buffer (2 entries, push/pop/flush, full/empty).

Verification
REQ-034 Reset release, zero-wait memory, ir_ready=1, memory words 16'h411F,16'h4207,16'h26C0 -> ir sequence matches with ir_pc 0,2,4 on consecutive cycles.
REQ-035 ir_ready=0 for 5 cycles -> after two acks imem_req=0 (HOLD), ir holds 16'h411F/pc 0; ir_ready=1 -> fetch resumes at addr 4, no loss or duplication.
REQ-036 2-cycle-latency memory, redirect to 16'h0041 while request to addr 6 outstanding -> DROP, returned word discarded, next imem_addr=16'h0040, ir_valid=0 until its data returns.
REQ-037 RESET_PC=16'hFFFC -> ir_pc sequence FFFC, FFFE, 0000, ir_next_pc at FFFE = 0000.
REQ-038 Full FIFO with simultaneous pop and ack -> occupancy stays 2, order preserved; reset asserted mid-request -> imem_req=0, ir_valid=0 next cycle, restart at RESET_PC.
